// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: PC register, request/grant instruction-memory port,
// and a DEPTH-entry FIFO of {instruction, PC} toward decode with branch redirect.
module fetch_prefetch #(
    parameter int unsigned   N        = 64,
    parameter int unsigned   IW       = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   STEP     = 4,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCSrc_F,
    input  logic [N-1:0]  PCBranch_F,
    output logic [N-1:0]  imem_addr_F,
    output logic          imem_req_F,
    input  logic          imem_gnt_F,
    input  logic          imem_rvalid_F,
    input  logic [IW-1:0] imem_rdata_F,
    output logic          valid_D,
    output logic [IW-1:0] instr_D,
    output logic [N-1:0]  pc_D,
    input  logic          ready_D
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t        state, state_next;
    logic [N-1:0]  pc, resp_pc;
    logic [IW-1:0] instr_mem [DEPTH];
    logic [N-1:0]  pc_mem    [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, inflight, discard;
    logic [CW:0]   used;
    logic          grant, push, pop, drop;

    // Live credits: buffered entries plus responses that will still be kept.
    assign used  = {1'b0, count} + {1'b0, inflight} - {1'b0, discard};
    assign grant = imem_req_F & imem_gnt_F;
    assign drop  = imem_rvalid_F & (discard != '0);
    assign push  = imem_rvalid_F & (discard == '0) & !PCSrc_F;
    assign pop   = valid_D & ready_D & !PCSrc_F;

    assign imem_addr_F = pc;
    assign valid_D     = (count != '0);
    assign instr_D     = instr_mem[rd_ptr];
    assign pc_D        = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        imem_req_F = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_RUN;
            ST_RUN:  imem_req_F = !PCSrc_F && (used < DEPTH_C);
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (PCSrc_F) begin
            // Every response still outstanding after this cycle belongs to the old path.
            pc       <= PCBranch_F;
            resp_pc  <= PCBranch_F;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight - CW'(imem_rvalid_F);
            discard  <= inflight - CW'(imem_rvalid_F);
        end else begin
            if (grant) pc <= pc + N'(STEP);
            if (push) begin
                resp_pc <= resp_pc + N'(STEP);
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)  rd_ptr  <= rd_ptr + PW'(1);
            if (drop) discard <= discard - CW'(1);
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(grant) - CW'(imem_rvalid_F);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata_F;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-cycle fetch stage: holds the PC, issues instruction-memory requests over a request/grant handshake, and buffers returned instructions (tagged with their PC) in a DEPTH-entry FIFO toward decode. Supports multiple outstanding memory requests, decode back-pressure, and branch redirect with flush and discard of in-flight responses. Sits between the branch-resolution logic (PCSrc_F/PCBranch_F) and the decode stage.

## Interface
- N, 64, address/PC width
- IW, 32, instruction width
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered instructions; power of two, ≥2
- STEP, 4, PC increment per sequential fetch
- RESET_PC, 0, PC after reset (N bits)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 resets all state immediately
- PCSrc_F  in  1  redirect request, single-cycle pulse or level
- PCBranch_F  in  N  redirect target, sampled when PCSrc_F=1
- imem_addr_F  out  N  request address (= PC register)
- imem_req_F  out  1  request valid
- imem_gnt_F  in  1  memory accepts request this cycle (only meaningful with imem_req_F=1)
- imem_rvalid_F  in  1  response valid; responses in request order, ≥1 cycle after grant
- imem_rdata_F  in  IW  response instruction
- valid_D  out  1  FIFO head valid
- instr_D  out  IW  FIFO head instruction
- pc_D  out  N  FIFO head PC
- ready_D  in  1  decode consumes head when valid_D=1

## Operation
- State: pc, resp_pc (PC of next non-discarded response), FIFO (count 0..DEPTH), inflight (0..DEPTH), discard (0..DEPTH), run flag.
- Reset: pc=resp_pc=RESET_PC, FIFO empty, inflight=discard=0, run=0; outputs imem_req_F=0, valid_D=0, imem_addr_F=RESET_PC. run sets 1 on first clock edge after reset released.
- imem_req_F = run & !PCSrc_F & (count + inflight − discard < DEPTH). Credit check guarantees every live response has a FIFO slot; FIFO never overflows.
- Grant (req & gnt): pc ← pc+STEP (mod 2^N, wraps silently), inflight+1.
- Response (rvalid): inflight−1. If discard>0: discard−1, data dropped. Else push {rdata, resp_pc}, resp_pc ← resp_pc+STEP.
- Pop: valid_D & ready_D removes head. Push and pop same cycle: count unchanged; push into empty FIFO is not visible until next cycle (registered FIFO, no bypass).
- Redirect (PCSrc_F=1), highest priority: pc ← PCBranch_F, resp_pc ← PCBranch_F, FIFO emptied (pop ignored), no request issued, discard ← inflight − rvalid, rvalid in that cycle dropped.
- rvalid with inflight=0 is a protocol error; behaviour undefined, assertion in bench.

## Timing
- Redirect at cycle t: imem_req_F=0 at t; imem_addr_F=PCBranch_F and request possible at t+1; valid_D=0 at t+1.
- Grant at t, response at t+k (k≥1): instruction at FIFO head visible at t+k+1 if FIFO was empty. Minimum fetch-to-decode latency 2 cycles.
- Throughput: 1 instruction/cycle sustained when memory latency k < DEPTH and ready_D=1.
- FIFO full (count=DEPTH) or credits exhausted: imem_req_F=0 same cycle combinationally; resumes the cycle after a pop frees credit.
- Reset asserted mid-operation: all state cleared asynchronously; outstanding memory responses after reset release are the memory's responsibility (memory is reset together).

## Test plan
- Reset release, gnt=1 always, latency 1, ready_D=1 -> imem_addr_F 0,4,8,... one per cycle from cycle 1; pc_D/instr_D stream 0,4,8 in order from cycle 3, no gaps.
- ready_D=0, latency 1 -> exactly DEPTH=4 grants (addr 0..12), then imem_req_F=0; valid_D=1 holding pc_D=0; ready_D=1 pulse -> one more request at addr 16.
- Latency 3, two grants outstanding, PCSrc_F=1 with PCBranch_F=0x100 -> both old responses dropped, first pc_D=0x100 with its instruction, FIFO contents before redirect never reach decode.
- Redirect in same cycle as rvalid and pop -> that response dropped, discard = remaining inflight, count=0 next cycle, req at 0x100 next cycle.
- RESET_PC=2^N−8, STEP=4 -> addresses 0x..F8, 0x..FC, 0x0 (wrap), pc_D follows.
- reset low for one cycle mid-stream with 3 instructions buffered -> valid_D=0, imem_req_F=0, imem_addr_F=RESET_PC immediately; fetch restarts from RESET_PC one edge after release.
